// File: rtl/mac_rx_ingress_pkg.sv
// Shared types and constants for the MAC receive ingress path.
// Holds the FSM state encoding and the FIFO word bit layout.
package mac_rx_ingress_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } state_e;

    localparam int ERR_BIT    = 34;
    localparam int EOP_BIT    = 33;
    localparam int SOP_BIT    = 32;
    localparam int FIFO_DEPTH = 512;

endpackage

// File: rtl/ingress_stats.sv
// Good/bad packet counters for the MAC receive ingress path.
// Present only when INGRESS_STATS_EN is defined.
module ingress_stats (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        pkt_eop_i,
    input  logic        pkt_error_i,
    output logic [31:0] pkt_count_o,
    output logic [31:0] err_count_o
);

    logic [31:0] pkt_count_q;
    logic [31:0] err_count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else if (pkt_eop_i) begin
            if (pkt_error_i) err_count_q <= err_count_q + 32'd1;
            else             pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count_o = pkt_count_q;
    assign err_count_o = err_count_q;

endmodule

// File: rtl/mac_rx_ingress.sv
// Avalon-ST MAC receive sink writing framed words into the input FIFO.
// Define INGRESS_STATS_EN to build the good/bad packet counters.
module mac_rx_ingress
    import mac_rx_ingress_pkg::*;
#(
    parameter int MAX_WORDS    = 380,
    parameter int AFULL_MARGIN = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic [1:0]  st_empty,
    input  logic        st_error,
    output logic        st_ready,
    input  logic [8:0]  fifo_wrusedw,
    output logic        fifo_wrreq,
    output logic [34:0] fifo_data,
    output logic        pkt_eop,
    output logic        pkt_error,
    output logic [15:0] pkt_len,
    output logic [31:0] rx_pkt_count,
    output logic [31:0] rx_err_count
);

    localparam logic [9:0]  AFULL_TH = 10'(FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [15:0] MAXW     = 16'(MAX_WORDS);

    state_e      state_q, state_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;
    logic        ready_q;
    logic        wr_q, wr_d;
    logic [34:0] data_q, data_d;
    logic        eop_q, eop_d;
    logic        perr_q, perr_d;
    logic [15:0] len_q, len_d;

    logic        acc;
    logic [15:0] cnt_n;
    logic        err_n;
    logic [15:0] full_len;
    logic [15:0] len_n;

    assign acc      = st_valid & ready_q;
    assign cnt_n    = wcnt_q + 16'd1;
    assign err_n    = err_q | st_error;
    assign full_len = {cnt_n[13:0], 2'b00};
    assign len_n    = full_len - {14'd0, st_empty};

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        eop_d   = 1'b0;
        perr_d  = 1'b0;
        len_d   = len_q;
        if (acc) begin
            unique case (state_q)
                IDLE: begin
                    if (st_sop) begin
                        wr_d    = 1'b1;
                        data_d  = {3'b001, st_data};
                        wcnt_d  = 16'd1;
                        err_d   = st_error;
                        state_d = RECV;
                        if (st_eop) begin
                            data_d[EOP_BIT] = 1'b1;
                            data_d[ERR_BIT] = st_error;
                            eop_d   = 1'b1;
                            perr_d  = st_error;
                            len_d   = 16'd4 - {14'd0, st_empty};
                            state_d = IDLE;
                        end
                    end else if (!st_eop) begin
                        state_d = DROP;
                    end
                end
                RECV: begin
                    wr_d = 1'b1;
                    if (st_sop) begin
                        // Close the open packet; the new one has lost its head.
                        data_d  = {3'b110, 32'd0};
                        eop_d   = 1'b1;
                        perr_d  = 1'b1;
                        len_d   = full_len;
                        state_d = DROP;
                    end else begin
                        data_d = {3'b000, st_data};
                        wcnt_d = cnt_n;
                        err_d  = err_n;
                        if (st_eop) begin
                            data_d[EOP_BIT] = 1'b1;
                            data_d[ERR_BIT] = err_n;
                            eop_d   = 1'b1;
                            perr_d  = err_n;
                            len_d   = len_n;
                            state_d = IDLE;
                        end else if (cnt_n == MAXW) begin
                            data_d[EOP_BIT] = 1'b1;
                            data_d[ERR_BIT] = 1'b1;
                            eop_d   = 1'b1;
                            perr_d  = 1'b1;
                            len_d   = full_len;
                            state_d = DROP;
                        end
                    end
                end
                DROP: begin
                    if (st_eop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            eop_q   <= 1'b0;
            perr_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            ready_q <= ({1'b0, fifo_wrusedw} < AFULL_TH);
            wr_q    <= wr_d;
            data_q  <= data_d;
            eop_q   <= eop_d;
            perr_q  <= perr_d;
            len_q   <= len_d;
        end
    end

    assign st_ready   = ready_q;
    assign fifo_wrreq = wr_q;
    assign fifo_data  = data_q;
    assign pkt_eop    = eop_q;
    assign pkt_error  = perr_q;
    assign pkt_len    = len_q;

`ifdef INGRESS_STATS_EN
    ingress_stats u_stats (
        .clk         (clk),
        .n_rst       (n_rst),
        .pkt_eop_i   (eop_q),
        .pkt_error_i (perr_q),
        .pkt_count_o (rx_pkt_count),
        .err_count_o (rx_err_count)
    );
`else
    assign rx_pkt_count = 32'd0;
    assign rx_err_count = 32'd0;
`endif

endmodule
